sdram_weight_reader: RTL
========================

// Module: sdram_weight_reader
// PURPOSE
//  Avalon-MM read master that fetches a contiguous byte block from the chatbot SDRAM.
//  It sits between the SoC SDRAM controller slave (8-bit data) and the intent-classifier datapath.
//  It issues pipelined single-byte reads and buffers the returned bytes in an internal FIFO.
//  It presents the bytes in address order on a valid/ready stream, and marks the final byte with st_last.
// PARAMETERS
//  ADDR_W      25  byte address width (13 row + 10 col + 2 bank)
//  DATA_W      8   data width; equals the SDRAM dq width
//  LEN_W       16  width of the transfer length in bytes
//  FIFO_DEPTH  16  depth of the return buffer; power of 2, >= 4
//  MAX_OUTST   8   maximum number of reads in flight; <= FIFO_DEPTH
// PORTS
//  clk_clk            in   1       system clock; all logic on the rising edge
//  reset_reset_n      in   1       asynchronous active-low reset
//  cmd_valid          in   1       a command is presented
//  cmd_ready          out  1       a command can be accepted (high only in IDLE)
//  cmd_addr           in   ADDR_W  start byte address
//  cmd_len            in   LEN_W   number of bytes to read; 0 is legal
//  avm_address        out  ADDR_W  Avalon read address
//  avm_read           out  1       Avalon read request
//  avm_waitrequest    in   1       slave stall
//  avm_readdata       in   DATA_W  returned byte
//  avm_readdatavalid  in   1       avm_readdata is valid this cycle
//  st_data            out  DATA_W  stream byte
//  st_valid           out  1       st_data is valid
//  st_ready           in   1       sink accepts the byte
//  st_last            out  1       qualifies the final byte of the command
//  busy               out  1       high from command accept until done
//  done               out  1       one-cycle pulse when the command completes
// BEHAVIOUR
//  Reset values: all outputs 0 except cmd_ready=1. Reset clears the state, the counters and the FIFO.
//  Reset mid-transfer: all state is discarded immediately. Responses that arrive after reset are ignored.
//  States:
//   IDLE  -> ISSUE on cmd_valid&&cmd_ready with cmd_len!=0.
//   IDLE  -> stays IDLE on a command with cmd_len==0; done pulses the next cycle; busy stays 0; no reads are issued.
//   ISSUE -> DRAIN when the cmd_len-th read is accepted.
//   DRAIN -> IDLE when the byte with st_last is accepted (st_valid&&st_ready&&st_last); done pulses in the same cycle as that transition.
//  Address and length are latched at accept. The first avm_read is asserted in the cycle after accept.
//  Issue credit: a new read may start only if outstanding < MAX_OUTST and outstanding + fifo_count < FIFO_DEPTH.
//  The FIFO can therefore never overflow.
//  Avalon hold rule: once avm_read=1, avm_address and avm_read hold unchanged until the first cycle with avm_waitrequest=0.
//  Acceptance = avm_read && !avm_waitrequest. On acceptance, outstanding increments and the address advances by 1 modulo 2^ADDR_W.
//  Address wrap: 2^ADDR_W-1 is followed by 0.
//  Back-to-back reads: with no stall, one read is accepted per cycle.
//  Return path: avm_readdatavalid writes the byte into the FIFO and decrements outstanding.
//  Simultaneous accept and return in one cycle: outstanding is unchanged.
//  Stream: st_valid = FIFO not empty; st_data = FIFO head (first-word fall-through).
//  Latency: minimum 1 cycle from avm_readdatavalid to st_valid.
//  Simultaneous FIFO push and pop: fifo_count is unchanged.
//  st_last = st_valid && (this is byte cmd_len of the command); a popped-byte counter drives it.
//  Back-pressure: st_ready=0 holds st_data/st_valid stable. Issue stalls only when the credit rule blocks it.
//  cmd_valid while busy: ignored (cmd_ready=0). No state change.
//  Arithmetic: outstanding is clog2(MAX_OUTST+1) bits; fifo_count is clog2(FIFO_DEPTH+1) bits; issue/pop counters are LEN_W bits. None may wrap.
// TESTING
//  1. addr=0x0000100, len=4, slave with 2-cycle read latency, st_ready=1:
//     -> reads 0x100..0x103 accepted in 4 consecutive cycles; stream yields 4 bytes in order;
//        st_last on the 4th byte; done pulses once; busy returns to 0.
//  2. len=0 -> no avm_read; done pulses the cycle after accept; cmd_ready stays 1.
//  3. avm_waitrequest=1 for 3 cycles on the first read
//     -> avm_address/avm_read held constant for 4 cycles; no address skip.
//  4. st_ready=0, len=40
//     -> avm_read stops after exactly 16 total reads issued (FIFO_DEPTH); resumes on st_ready=1;
//        all 40 bytes delivered in order.
//  5. addr=0x1FFFFFE, len=4 -> addresses 0x1FFFFFE, 0x1FFFFFF, 0x0000000, 0x0000001.
//  6. reset_reset_n low mid-transfer with 3 reads in flight -> all outputs at reset values immediately;
//     next command with len=2 completes normally with exactly 2 bytes.

Source files
------------

// File: rtl/sdram_weight_reader.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_weight_reader
//  Purpose  : Avalon-MM read master that fetches a contiguous byte block from
//             SDRAM with pipelined single-byte reads. Returned bytes are
//             buffered and replayed in order on a valid/ready stream.
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_weight_reader #(
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_OUTST  = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_last,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTST + 1);
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    issued_q, issued_d;
  logic [LEN_W-1:0]    popped_q, popped_d;
  logic [OUT_W-1:0]    outst_q, outst_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic                zdone_q, zdone_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

  logic                cmd_fire;
  logic                credit_ok;
  logic                rd_accept;
  logic                push;
  logic                pop;
  logic                last_byte;
  logic [SUM_W-1:0]    inflight_sum;

  // State, counters and FIFO pointers; async reset discards any transfer.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      popped_q <= '0;
      outst_q  <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      zdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      popped_q <= popped_d;
      outst_q  <= outst_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      zdone_q  <= zdone_d;
    end
  end

  // Return-buffer storage; contents are meaningless while count_q is zero.
  always_ff @(posedge clk_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= avm_readdata;
    end
  end

  // Next-state, issue credit, FIFO bookkeeping and stream outputs.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    issued_d  = issued_q;
    popped_d  = popped_q;
    outst_d   = outst_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    zdone_d   = 1'b0;

    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    cmd_fire  = cmd_valid && cmd_ready;

    // Credit only improves while a read is stalled (returns move bytes from
    // in-flight to buffered, pops shrink the total), so avm_read derived
    // from it never drops during a waitrequest stall.
    inflight_sum = SUM_W'(outst_q) + SUM_W'(count_q);
    credit_ok    = (outst_q < OUT_W'(MAX_OUTST)) &&
                   (inflight_sum < SUM_W'(FIFO_DEPTH));
    avm_read     = (state_q == S_ISSUE) && credit_ok;
    avm_address  = addr_q;
    rd_accept    = avm_read && !avm_waitrequest;

    // Responses with nothing in flight are leftovers from before a reset.
    push      = avm_readdatavalid && (outst_q != '0);
    st_valid  = (count_q != '0);
    st_data   = st_valid ? mem_q[rd_ptr_q] : '0;
    last_byte = (popped_q == (len_q - LEN_W'(1)));
    st_last   = st_valid && (state_q != S_IDLE) && last_byte;
    pop       = st_valid && st_ready;
    done      = zdone_q || (pop && st_last);

    unique case ({rd_accept, push})
      2'b10:   outst_d = outst_q + OUT_W'(1);
      2'b01:   outst_d = outst_q - OUT_W'(1);
      default: outst_d = outst_q;
    endcase

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      popped_d = popped_q + LEN_W'(1);
    end
    if (rd_accept) begin
      addr_d   = addr_q + ADDR_W'(1);
      issued_d = issued_q + LEN_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          if (cmd_len == '0) begin
            zdone_d = 1'b1;
          end else begin
            state_d  = S_ISSUE;
            addr_d   = cmd_addr;
            len_d    = cmd_len;
            issued_d = '0;
            popped_d = '0;
          end
        end
      end
      S_ISSUE: begin
        if (rd_accept && ((issued_q + LEN_W'(1)) == len_q)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && st_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire
